// File: rtl/sram_1rw1r_clr_if.sv
// Port bundle for the 1RW1R SRAM: RW and R request/response signals plus clear status.
interface sram_1rw1r_clr_if #(
    parameter int unsigned BITS       = 32,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned MASK_W     = 4
);
    logic                  init_busy;
    logic                  ce_rw1;
    logic                  we_in_rw1;
    logic [MASK_W-1:0]     w_mask_rw1;
    logic [ADDR_WIDTH-1:0] addr_rw1;
    logic [BITS-1:0]       wd_in_rw1;
    logic [BITS-1:0]       rd_out_rw1;
    logic                  rd_valid_rw1;
    logic                  rd_err_rw1;
    logic                  ce_r1;
    logic [ADDR_WIDTH-1:0] addr_r1;
    logic [BITS-1:0]       rd_out_r1;
    logic                  rd_valid_r1;
    logic                  rd_err_r1;

    modport master (
        input  init_busy, rd_out_rw1, rd_valid_rw1, rd_err_rw1,
               rd_out_r1, rd_valid_r1, rd_err_r1,
        output ce_rw1, we_in_rw1, w_mask_rw1, addr_rw1, wd_in_rw1,
               ce_r1, addr_r1
    );

    modport slave (
        output init_busy, rd_out_rw1, rd_valid_rw1, rd_err_rw1,
               rd_out_r1, rd_valid_r1, rd_err_r1,
        input  ce_rw1, we_in_rw1, w_mask_rw1, addr_rw1, wd_in_rw1,
               ce_r1, addr_r1
    );
endinterface

// File: rtl/sram_1rw1r_clr.sv
// Behavioural 1RW1R SRAM with hardware clear, read strobes, write forwarding and range checks.
module sram_1rw1r_clr #(
    parameter int unsigned BITS           = 32,
    parameter int unsigned WORD_DEPTH     = 384,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned MASK_GRAN      = 8,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic               clk0,
    input  logic               rst,
    sram_1rw1r_clr_if.slave    bus
);
    localparam int unsigned MASK_W = BITS / MASK_GRAN;
    localparam int unsigned IDX_W  = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH+1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic [BITS-1:0]       mem [WORD_DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MASK_W-1:0]     mem_lane;
    logic [BITS-1:0]       mem_wdata;
    logic                  acc_rw, acc_r, rw_wr;
    logic                  rw_in_range, r_in_range;
    logic [BITS-1:0]       bit_mask;
    logic [BITS-1:0]       rw_rd, r_rd;

    logic                  v1_rw, e1_rw, v1_r, e1_r;
    logic [BITS-1:0]       d1_rw, d1_r;

    assign rw_in_range   = ({1'b0, bus.addr_rw1} < DEPTH_L);
    assign r_in_range    = ({1'b0, bus.addr_r1}  < DEPTH_L);
    assign bus.init_busy = (state_q == CLEAR);

    // State and clear-counter register; reset restarts the clear at word 0.
    always_ff @(posedge clk0) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, clear sequencing and port acceptance; requests are dropped while clearing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = bus.addr_rw1;
        mem_lane  = bus.w_mask_rw1;
        mem_wdata = bus.wd_in_rw1;
        acc_rw    = 1'b0;
        acc_r     = 1'b0;
        rw_wr     = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_lane  = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                acc_rw = bus.ce_rw1;
                acc_r  = bus.ce_r1;
                rw_wr  = bus.ce_rw1 & bus.we_in_rw1 & rw_in_range;
                mem_we = rw_wr;
            end
        endcase
    end

    // Lane mask expanded to one bit per data bit for forwarding.
    always_comb begin
        bit_mask = '0;
        for (int k = 0; k < MASK_W; k++) begin
            bit_mask[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{bus.w_mask_rw1[k]}};
        end
    end

    // Read-first array reads; the R port sees a colliding write through forwarding.
    always_comb begin
        rw_rd = '0;
        r_rd  = '0;
        if (rw_in_range) rw_rd = mem[IDX_W'(bus.addr_rw1)];
        if (r_in_range)  r_rd  = mem[IDX_W'(bus.addr_r1)];
        if (rw_wr && (bus.addr_r1 == bus.addr_rw1)) begin
            r_rd = (bus.wd_in_rw1 & bit_mask) | (r_rd & ~bit_mask);
        end
    end

    // Lane-masked array write, shared by the clear sequencer and the RW port.
    always_ff @(posedge clk0) begin
        if (mem_we && !rst) begin
            for (int k = 0; k < MASK_W; k++) begin
                if (mem_lane[k]) begin
                    mem[IDX_W'(mem_addr)][k*MASK_GRAN +: MASK_GRAN] <= mem_wdata[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // First output stage: strobe and error every cycle, data held when idle.
    always_ff @(posedge clk0) begin
        if (rst) begin
            v1_rw <= 1'b0;
            e1_rw <= 1'b0;
            d1_rw <= '0;
            v1_r  <= 1'b0;
            e1_r  <= 1'b0;
            d1_r  <= '0;
        end else begin
            v1_rw <= acc_rw;
            e1_rw <= acc_rw & ~rw_in_range;
            v1_r  <= acc_r;
            e1_r  <= acc_r & ~r_in_range;
            if (acc_rw) d1_rw <= rw_rd;
            if (acc_r)  d1_r  <= r_rd;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic            v2_rw, e2_rw, v2_r, e2_r;
            logic [BITS-1:0] d2_rw, d2_r;

            // Optional second output stage adding one cycle of read latency.
            always_ff @(posedge clk0) begin
                if (rst) begin
                    v2_rw <= 1'b0;
                    e2_rw <= 1'b0;
                    d2_rw <= '0;
                    v2_r  <= 1'b0;
                    e2_r  <= 1'b0;
                    d2_r  <= '0;
                end else begin
                    v2_rw <= v1_rw;
                    e2_rw <= e1_rw;
                    v2_r  <= v1_r;
                    e2_r  <= e1_r;
                    if (v1_rw) d2_rw <= d1_rw;
                    if (v1_r)  d2_r  <= d1_r;
                end
            end

            assign bus.rd_valid_rw1 = v2_rw;
            assign bus.rd_err_rw1   = e2_rw;
            assign bus.rd_out_rw1   = d2_rw;
            assign bus.rd_valid_r1  = v2_r;
            assign bus.rd_err_r1    = e2_r;
            assign bus.rd_out_r1    = d2_r;
        end else begin : g_no_out_reg
            assign bus.rd_valid_rw1 = v1_rw;
            assign bus.rd_err_rw1   = e1_rw;
            assign bus.rd_out_rw1   = d1_rw;
            assign bus.rd_valid_r1  = v1_r;
            assign bus.rd_err_r1    = e1_r;
            assign bus.rd_out_r1    = d1_r;
        end
    endgenerate
endmodule

// File: tb/tb_sram_1rw1r_clr.sv
// Directed self-checking bench for sram_1rw1r_clr (default build and an OUT_REG=1 build).
module tb_sram_1rw1r_clr;
    logic clk0 = 1'b0;
    logic rst  = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk0 = ~clk0;

    sram_1rw1r_clr_if #(.BITS(32), .ADDR_WIDTH(9), .MASK_W(4)) b0 ();
    sram_1rw1r_clr_if #(.BITS(32), .ADDR_WIDTH(5), .MASK_W(4)) b1 ();

    sram_1rw1r_clr dut0 (
        .clk0 (clk0),
        .rst  (rst),
        .bus  (b0.slave)
    );

    sram_1rw1r_clr #(
        .WORD_DEPTH (16),
        .ADDR_WIDTH (5),
        .OUT_REG    (1)
    ) dut1 (
        .clk0 (clk0),
        .rst  (rst),
        .bus  (b1.slave)
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk0);
    endtask

    task automatic idle0();
        b0.ce_rw1 = 1'b0; b0.we_in_rw1 = 1'b0; b0.w_mask_rw1 = '0;
        b0.addr_rw1 = '0; b0.wd_in_rw1 = '0; b0.ce_r1 = 1'b0; b0.addr_r1 = '0;
    endtask

    task automatic idle1();
        b1.ce_rw1 = 1'b0; b1.we_in_rw1 = 1'b0; b1.w_mask_rw1 = '0;
        b1.addr_rw1 = '0; b1.wd_in_rw1 = '0; b1.ce_r1 = 1'b0; b1.addr_r1 = '0;
    endtask

    task automatic rw0(input logic we, input logic [3:0] m, input logic [8:0] a, input logic [31:0] d);
        b0.ce_rw1 = 1'b1; b0.we_in_rw1 = we; b0.w_mask_rw1 = m;
        b0.addr_rw1 = a; b0.wd_in_rw1 = d;
    endtask

    task automatic r0(input logic [8:0] a);
        b0.ce_r1 = 1'b1; b0.addr_r1 = a;
    endtask

    initial begin
        int n;
        int strobes;
        idle0();
        idle1();

        // Reset state
        repeat (3) tick();
        check("rst_busy0",  32'(b0.init_busy), 32'd1);
        check("rst_busy1",  32'(b1.init_busy), 32'd1);
        check("rst_vrw",    32'(b0.rd_valid_rw1), 32'd0);
        check("rst_vr",     32'(b0.rd_valid_r1), 32'd0);
        check("rst_drw",    b0.rd_out_rw1, 32'h0);

        // Clear sequence length after rst falls
        rst = 1'b0;
        n = 0;
        while (b0.init_busy && n < 1000) begin
            n++;
            tick();
        end
        check("clear_len", 32'(n), 32'd384);

        // First and last word cleared
        rw0(1'b0, 4'h0, 9'd0, 32'h0);
        r0(9'd383);
        tick();
        check("clr_rd0",  b0.rd_out_rw1, 32'h0);
        check("clr_v0",   32'(b0.rd_valid_rw1), 32'd1);
        check("clr_e0",   32'(b0.rd_err_rw1), 32'd0);
        check("clr_rd383", b0.rd_out_r1, 32'h0);
        check("clr_v383", 32'(b0.rd_valid_r1), 32'd1);
        check("clr_e383", 32'(b0.rd_err_r1), 32'd0);
        idle0();
        tick();
        check("strobe_1cyc", 32'({b0.rd_valid_rw1, b0.rd_valid_r1}), 32'd0);

        // Masked write with read-first strobe
        rw0(1'b1, 4'b1111, 9'd5, 32'hAABBCCDD);
        tick();
        rw0(1'b1, 4'b0101, 9'd5, 32'h11223344);
        tick();
        check("rdfirst_d", b0.rd_out_rw1, 32'hAABBCCDD);
        check("rdfirst_v", 32'(b0.rd_valid_rw1), 32'd1);
        rw0(1'b0, 4'h0, 9'd5, 32'h0);
        r0(9'd5);
        tick();
        check("mask_rw", b0.rd_out_rw1, 32'hAA22CC44);
        check("mask_r",  b0.rd_out_r1,  32'hAA22CC44);
        idle0();
        tick();
        check("hold_v", 32'(b0.rd_valid_rw1), 32'd0);
        check("hold_d", b0.rd_out_rw1, 32'hAA22CC44);

        // Collision forwarding
        rw0(1'b1, 4'b0011, 9'd7, 32'hDEADBEEF);
        r0(9'd7);
        tick();
        check("fwd_r",  b0.rd_out_r1,  32'h0000BEEF);
        check("fwd_rw", b0.rd_out_rw1, 32'h00000000);
        idle0();
        rw0(1'b0, 4'h0, 9'd7, 32'h0);
        tick();
        check("fwd_mem", b0.rd_out_rw1, 32'h0000BEEF);

        // Out-of-range accesses
        idle0();
        rw0(1'b1, 4'hF, 9'd400, 32'hFFFFFFFF);
        tick();
        check("oor_wr_d", b0.rd_out_rw1, 32'h0);
        check("oor_wr_e", 32'(b0.rd_err_rw1), 32'd1);
        rw0(1'b0, 4'h0, 9'd400, 32'h0);
        r0(9'd400);
        tick();
        check("oor_rw_d", b0.rd_out_rw1, 32'h0);
        check("oor_rw_e", 32'(b0.rd_err_rw1), 32'd1);
        check("oor_r_d",  b0.rd_out_r1, 32'h0);
        check("oor_r_e",  32'(b0.rd_err_r1), 32'd1);
        rw0(1'b0, 4'h0, 9'd16, 32'h0);
        r0(9'd384);
        tick();
        check("alias16_d", b0.rd_out_rw1, 32'h0);
        check("alias16_e", 32'(b0.rd_err_rw1), 32'd0);
        check("r384_e",    32'(b0.rd_err_r1), 32'd1);
        check("r384_v",    32'(b0.rd_valid_r1), 32'd1);
        idle0();
        tick();
        check("err_pulse", 32'(b0.rd_err_r1), 32'd0);

        // Reset mid-clear with requests pending throughout
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rw0(1'b1, 4'hF, 9'd5, 32'h12345678);
        r0(9'd5);
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (b0.rd_valid_rw1 || b0.rd_valid_r1) strobes++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (b0.init_busy && n < 1000) begin
            if (b0.rd_valid_rw1 || b0.rd_valid_r1) strobes++;
            n++;
            tick();
        end
        idle0();
        check("restart_len", 32'(n), 32'd384);
        check("busy_strobes", 32'(strobes), 32'd0);
        rw0(1'b0, 4'h0, 9'd5, 32'h0);
        r0(9'd5);
        tick();
        check("restart_rw5", b0.rd_out_rw1, 32'h0);
        check("restart_r5",  b0.rd_out_r1,  32'h0);
        idle0();

        // OUT_REG = 1: back-to-back reads, two-cycle latency
        for (int i = 1; i <= 3; i++) begin
            b1.ce_rw1 = 1'b1; b1.we_in_rw1 = 1'b1; b1.w_mask_rw1 = 4'hF;
            b1.addr_rw1 = 5'(i); b1.wd_in_rw1 = 32'(32'h11111111 * i);
            tick();
        end
        idle1();
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                b1.ce_rw1 = 1'b1; b1.we_in_rw1 = 1'b0; b1.addr_rw1 = 5'(i + 1);
                b1.ce_r1  = 1'b1; b1.addr_r1 = 5'(3 - i);
            end else begin
                idle1();
            end
            tick();
            if (i >= 1 && i <= 3) begin
                check("oreg_v_rw", 32'(b1.rd_valid_rw1), 32'd1);
                check("oreg_d_rw", b1.rd_out_rw1, 32'(32'h11111111 * i));
                check("oreg_v_r",  32'(b1.rd_valid_r1), 32'd1);
                check("oreg_d_r",  b1.rd_out_r1, 32'(32'h11111111 * (4 - i)));
            end else begin
                check("oreg_idle_v", 32'({b1.rd_valid_rw1, b1.rd_valid_r1}), 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
